adder_rom_sequencer: RTL and testbench
======================================

// Module: adder_rom_sequencer
// PURPOSE
//  Time-multiplexes one shared adder_ROM lookup table between NREQ requesters.
//  Round-robin arbiter grants one requester, snapshots its NBYTES-byte vector,
//  walks the bytes through the ROM one per clock and accumulates the 5-bit
//  outputs into a sum. Returns the sum with a one-cycle done pulse to the
//  granted requester. Sits between GTP trigger-sum clients and the single ROM.
// PARAMETERS
//  NREQ    4  number of requesters (2..8)
//  NBYTES  4  bytes per request vector (1..16)
//  SUM_W   7  result width = 5 + clog2(NBYTES); sized so the sum never overflows
// PORTS
//  clk        in   1             single system clock, all logic on rising edge
//  rst        in   1             synchronous, active-high reset
//  req        in   NREQ          level request per requester, held until done
//  req_data   in   NREQ*NBYTES*8 requester i vector at [i*NBYTES*8 +: NBYTES*8]; byte 0 = LSB
//  rom_addr   out  8             address to shared adder_ROM (asynchronous read)
//  rom_data   in   5             ROM output, same cycle as rom_addr
//  done       out  NREQ          one-hot, 1-cycle pulse: result valid for that requester
//  result     out  SUM_W         accumulated sum; stable until the next done
//  result_id  out  clog2(NREQ)   index of the requester owning result
//  busy       out  1             high in RUN and DONE
// BEHAVIOUR
//  Reset: state=IDLE, done=0, result=0, result_id=0, busy=0, rom_addr=0,
//   acc=0, byte_idx=0, rr pointer = last grant NREQ-1 (requester 0 has top priority).
//  FSM IDLE -> RUN -> DONE -> IDLE.
//   IDLE: if |req, grant first set bit searching upward from (last_grant+1)
//    mod NREQ. At that edge: latch grant index, snapshot that requester's vector,
//    byte_idx=0, acc=0, go RUN. If no request, remain IDLE.
//   RUN: rom_addr = snapshot byte[byte_idx] (mux of registers, no comb path
//    from req_data). Each edge: acc += rom_data, zero-extended; byte_idx++.
//    On the edge that adds byte NBYTES-1, go DONE.
//   DONE: result = acc, result_id = grant, done[grant] = 1 for exactly this
//    cycle, update last_grant, go IDLE.
//  Latency: grant edge G; RUN occupies cycles G+1..G+NBYTES; done is high in
//   cycle G+NBYTES+1. Throughput is one request per NBYTES+2 cycles.
//  rom_addr is 0 outside RUN. The ROM is only read in RUN.
//  Handshake: requester deasserts req on the edge where it samples done high.
//   IDLE follows DONE, so a requester that drops req on time is never re-granted
//   for the same transaction.
//  req_data changes after grant are ignored (snapshot).
//  req dropped mid-RUN: the transaction still completes and done still pulses.
//  Simultaneous requests: strict round-robin; no requester waits more than
//   NREQ-1 transactions.
//  rst in any state: abort immediately to reset values; no done pulse for the
//   aborted transaction.
//  Boundaries:
//   NBYTES=1: RUN lasts one cycle.
//   Maximum sum NBYTES*31 fits SUM_W.
//   byte_idx wraps only via reset or IDLE.
// STRUCTURE
//  Shared header adder_seq_defs.vh:
//   state encodings S_IDLE=2'd0, S_RUN=2'd1, S_DONE=2'd2;
//   clog2 function; ROM_AW=8; ROM_DW=5.
//  Sub-module rr_arbiter:
//   NREQ-wide round-robin arbiter, combinational grant from req and last_grant,
//   one-hot plus index outputs.
//  The ROM is instantiated next to this block, not inside it.
// TESTING (bench ROM model: data = popcount(addr))
//  1. rst, then req=4'b0001 with vector 0xFF0F0301 -> done=4'b0001 5 cycles
//     after the grant edge, result=15, result_id=0.
//  2. req=4'b1111 held, then each requester drops req on its done -> grant order
//     0,1,2,3; done pulses spaced 6 cycles apart.
//  3. After requester 2 completes, req=4'b0101 -> requester 0 is granted before 2
//     (pointer wrap).
//  4. req_data changed to 0x00000000 one cycle after grant with 0xFFFFFFFF
//     latched -> result=32.
//  5. rst asserted in the 2nd RUN cycle -> no done, busy=0 on the next cycle,
//     next request is served by requester 0 first.
//  6. Requester 1 drops req mid-RUN -> done[1] still pulses, then IDLE with busy=0.

Source files
------------

// File: rtl/adder_rom_sequencer_pkg.sv
// Shared definitions for the adder ROM sequencer: FSM encodings, ROM
// geometry and a constant-evaluable ceil(log2) helper.
package adder_rom_sequencer_pkg;

    localparam int ROM_AW = 8;
    localparam int ROM_DW = 5;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } seq_state_t;

    // Smallest r with 2**r >= v; returns 0 for v <= 1.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/adder_rom_sequencer_rr_arbiter.sv
// Combinational round-robin arbiter. The search starts one position above
// the last granted requester and wraps, so the most recently served
// requester has the lowest priority.
module adder_rom_sequencer_rr_arbiter
    import adder_rom_sequencer_pkg::*;
#(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0]        req_i,
    input  logic [clog2(NREQ)-1:0] last_grant_i,
    output logic [NREQ-1:0]        grant_oh_o,
    output logic [clog2(NREQ)-1:0] grant_idx_o,
    output logic                   valid_o
);

    localparam int IDX_W = clog2(NREQ);

    logic found;
    int   cand;

    // First set request bit searching upward from last_grant+1, modulo NREQ.
    always_comb begin
        grant_oh_o  = '0;
        grant_idx_o = '0;
        found       = 1'b0;
        cand        = 0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = (int'(last_grant_i) + k) % NREQ;
            if (!found && req_i[cand]) begin
                found       = 1'b1;
                grant_idx_o = IDX_W'(cand);
            end
        end
        if (found) begin
            grant_oh_o[grant_idx_o] = 1'b1;
        end
        valid_o = found;
    end

endmodule

// File: rtl/adder_rom_sequencer.sv
// Time-multiplexes a single adder ROM between NREQ requesters. A granted
// requester's byte vector is snapshotted, each byte is looked up in the ROM
// on consecutive clocks, and the 5-bit outputs are summed. The sum is
// returned with a one-cycle done pulse to the owner.
//
//   state  | meaning
//   -------+------------------------------------------------------------
//   IDLE   | waiting for any request; arbiter picks the next owner
//   RUN    | one snapshot byte per clock drives rom_addr, acc += rom_data
//   DONE   | result/result_id valid, done pulses for the owner
module adder_rom_sequencer
    import adder_rom_sequencer_pkg::*;
#(
    parameter int NREQ   = 4,
    parameter int NBYTES = 4,
    parameter int SUM_W  = 7
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ*NBYTES*8-1:0] req_data,
    output logic [ROM_AW-1:0]        rom_addr,
    input  logic [ROM_DW-1:0]        rom_data,
    output logic [NREQ-1:0]          done,
    output logic [SUM_W-1:0]         result,
    output logic [clog2(NREQ)-1:0]   result_id,
    output logic                     busy
);

    localparam int IDX_W = clog2(NREQ);
    localparam int BI_W  = (NBYTES > 1) ? clog2(NBYTES) : 1;
    localparam int VEC_W = NBYTES * 8;

    seq_state_t       state_q, state_d;
    logic [IDX_W-1:0] grant_idx_q, grant_idx_d;
    logic [NREQ-1:0]  grant_oh_q, grant_oh_d;
    logic [IDX_W-1:0] last_grant_q, last_grant_d;
    logic [VEC_W-1:0] snap_q, snap_d;
    logic [BI_W-1:0]  byte_idx_q, byte_idx_d;
    logic [SUM_W-1:0] acc_q, acc_d;
    logic [SUM_W-1:0] result_q, result_d;
    logic [IDX_W-1:0] result_id_q, result_id_d;

    logic [NREQ-1:0]  arb_oh;
    logic [IDX_W-1:0] arb_idx;
    logic             arb_valid;

    adder_rom_sequencer_rr_arbiter #(
        .NREQ(NREQ)
    ) u_arb (
        .req_i       (req),
        .last_grant_i(last_grant_q),
        .grant_oh_o  (arb_oh),
        .grant_idx_o (arb_idx),
        .valid_o     (arb_valid)
    );

    // State and datapath registers; reset aborts any transaction in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            grant_idx_q  <= '0;
            grant_oh_q   <= '0;
            last_grant_q <= IDX_W'(NREQ - 1);
            snap_q       <= '0;
            byte_idx_q   <= '0;
            acc_q        <= '0;
            result_q     <= '0;
            result_id_q  <= '0;
        end else begin
            state_q      <= state_d;
            grant_idx_q  <= grant_idx_d;
            grant_oh_q   <= grant_oh_d;
            last_grant_q <= last_grant_d;
            snap_q       <= snap_d;
            byte_idx_q   <= byte_idx_d;
            acc_q        <= acc_d;
            result_q     <= result_d;
            result_id_q  <= result_id_d;
        end
    end

    // Next-state and datapath update. The result is loaded on the edge that
    // adds the last byte so it is already valid while done is high.
    always_comb begin
        state_d      = state_q;
        grant_idx_d  = grant_idx_q;
        grant_oh_d   = grant_oh_q;
        last_grant_d = last_grant_q;
        snap_d       = snap_q;
        byte_idx_d   = byte_idx_q;
        acc_d        = acc_q;
        result_d     = result_q;
        result_id_d  = result_id_q;
        case (state_q)
            S_IDLE: begin
                if (arb_valid) begin
                    grant_idx_d = arb_idx;
                    grant_oh_d  = arb_oh;
                    snap_d      = req_data[int'(arb_idx)*VEC_W +: VEC_W];
                    byte_idx_d  = '0;
                    acc_d       = '0;
                    state_d     = S_RUN;
                end
            end
            S_RUN: begin
                acc_d = acc_q + SUM_W'(rom_data);
                if (byte_idx_q == BI_W'(NBYTES - 1)) begin
                    result_d    = acc_d;
                    result_id_d = grant_idx_q;
                    state_d     = S_DONE;
                end else begin
                    byte_idx_d = byte_idx_q + BI_W'(1);
                end
            end
            S_DONE: begin
                last_grant_d = grant_idx_q;
                byte_idx_d   = '0;
                state_d      = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs decoded from registers only; rom_addr never sees req_data directly.
    always_comb begin
        rom_addr = '0;
        if (state_q == S_RUN) begin
            rom_addr = snap_q[int'(byte_idx_q)*8 +: 8];
        end
        done      = (state_q == S_DONE) ? grant_oh_q : '0;
        busy      = (state_q == S_RUN) || (state_q == S_DONE);
        result    = result_q;
        result_id = result_id_q;
    end

endmodule

// File: tb/tb_adder_rom_sequencer.sv
// Scoreboard bench for adder_rom_sequencer with a popcount ROM model.
module tb_adder_rom_sequencer;

    localparam int NREQ   = 4;
    localparam int NBYTES = 4;
    localparam int SUM_W  = 7;

    logic                     clk = 1'b0;
    logic                     rst = 1'b1;
    logic [NREQ-1:0]          req = '0;
    logic [NREQ*NBYTES*8-1:0] req_data = '0;
    logic [7:0]               rom_addr;
    logic [4:0]               rom_data;
    logic [NREQ-1:0]          done;
    logic [SUM_W-1:0]         result;
    logic [1:0]               result_id;
    logic                     busy;

    int cyc = 0;
    int checks = 0;
    int errors = 0;

    typedef struct {
        int id;
        int sum;
        int cyc;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    assign rom_data = 5'($countones(rom_addr));

    adder_rom_sequencer #(
        .NREQ(NREQ),
        .NBYTES(NBYTES),
        .SUM_W(SUM_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .req_data (req_data),
        .rom_addr (rom_addr),
        .rom_data (rom_data),
        .done     (done),
        .result   (result),
        .result_id(result_id),
        .busy     (busy)
    );

    function automatic void chk(input string name, input int act, input int exp_v);
        checks = checks + 1;
        if (act != exp_v) begin
            errors = errors + 1;
            $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp_v, cyc);
        end
    endfunction

    // Expected done cycle: grant on the next edge plus NBYTES, plus an offset
    // of whole transactions (NBYTES+2 cycles each) queued ahead of this one.
    task automatic expect_txn(input int id, input int sum, input int slot);
        exp_t e;
        e.id  = id;
        e.sum = sum;
        e.cyc = cyc + 1 + NBYTES + slot * (NBYTES + 2);
        sb.push_back(e);
    endtask

    // One clock; requesters that saw their done bit drop req after the edge.
    task automatic tick();
        logic [NREQ-1:0] d;
        d = rst ? '0 : done;
        @(posedge clk);
        #1;
        req = req & ~d;
    endtask

    task automatic drain(input int maxc);
        int n;
        n = 0;
        while ((sb.size() != 0 || busy) && n < maxc) begin
            tick();
            n++;
        end
        chk("drain_busy", int'(busy), 0);
        chk("drain_pending", sb.size(), 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = '0;
        tick();
        tick();
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_result", int'(result), 0);
        chk("rst_result_id", int'(result_id), 0);
        chk("rst_rom_addr", int'(rom_addr), 0);
        rst = 1'b0;
    endtask

    initial begin
        exp_t e;

        fork
            forever begin
                @(negedge clk);
                if (!rst) begin
                    if (!busy) chk("rom_addr_idle", int'(rom_addr), 0);
                    if (done != '0) begin
                        if (sb.size() == 0) begin
                            chk("unexpected_done", int'(done), 0);
                        end else begin
                            e = sb.pop_front();
                            chk("done_onehot", int'(done), 1 << e.id);
                            chk("result", int'(result), e.sum);
                            chk("result_id", int'(result_id), e.id);
                            chk("done_cycle", cyc, e.cyc);
                        end
                    end
                end
            end
        join_none

        // 1: single request, popcounts 1+2+4+8
        do_reset();
        req_data[0*32 +: 32] = 32'hFF0F_0301;
        req = 4'b0001;
        expect_txn(0, 15, 0);
        drain(20);

        // 2: all four requesting from reset -> 0,1,2,3, six cycles apart
        do_reset();
        req_data[0*32 +: 32] = 32'h0101_0101;
        req_data[1*32 +: 32] = 32'h0303_0303;
        req_data[2*32 +: 32] = 32'h0F0F_0F0F;
        req_data[3*32 +: 32] = 32'h7F3F_1F07;
        req = 4'b1111;
        expect_txn(0, 4, 0);
        expect_txn(1, 8, 1);
        expect_txn(2, 16, 2);
        expect_txn(3, 21, 3);
        drain(40);

        // 3: after requester 2, pointer wraps so 0 beats 2
        do_reset();
        req_data[2*32 +: 32] = 32'h0000_00FF;
        req = 4'b0100;
        expect_txn(2, 8, 0);
        drain(20);
        req_data[0*32 +: 32] = 32'h0000_0001;
        req = 4'b0101;
        expect_txn(0, 1, 0);
        expect_txn(2, 8, 1);
        drain(30);

        // 4: vector changed one cycle after grant is ignored
        req_data[1*32 +: 32] = 32'hFFFF_FFFF;
        req = 4'b0010;
        expect_txn(1, 32, 0);
        tick();
        req_data[1*32 +: 32] = 32'h0000_0000;
        drain(20);

        // 5: reset in the second RUN cycle aborts silently
        req_data[0*32 +: 32] = 32'h0101_0101;
        req = 4'b0001;
        tick();
        tick();
        chk("abort_busy_before", int'(busy), 1);
        rst = 1'b1;
        tick();
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(done), 0);
        chk("abort_result", int'(result), 0);
        rst = 1'b0;
        req_data[1*32 +: 32] = 32'h0000_0003;
        req = 4'b0011;
        expect_txn(0, 4, 0);
        expect_txn(1, 2, 1);
        drain(30);

        // 6: requester 1 drops req mid-RUN, transaction still completes
        req_data[1*32 +: 32] = 32'h0000_0F0F;
        req = 4'b0010;
        expect_txn(1, 8, 0);
        tick();
        tick();
        req = 4'b0000;
        drain(20);
        tick();
        chk("after_drop_busy", int'(busy), 0);
        chk("after_drop_rom_addr", int'(rom_addr), 0);

        chk("sb_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
